// File: rtl/mq_fifo_pkg.sv
// mq_fifo_pkg: shared types and constants for the multi-queue FIFO push path.
package mq_fifo_pkg;
    localparam int MQ_Q = 4;
    localparam logic [1:0] SKID_DEPTH = 2'd2;
    typedef logic [$clog2(MQ_Q)-1:0] qid_t;
endpackage

// File: rtl/mq_push_skid.sv
// mq_push_skid: 2-entry skid buffer with a registered ready, one per producer.
module mq_push_skid
    import mq_fifo_pkg::*;
#(
    parameter int QW = 2,
    parameter int W  = 32
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          valid,
    output logic          ready,
    input  logic [QW-1:0] q,
    input  logic [W-1:0]  data,
    input  logic          pop,
    output logic          head_vld,
    output logic [QW-1:0] head_q,
    output logic [W-1:0]  head_d
);
    typedef struct packed {
        logic [QW-1:0] q;
        logic [W-1:0]  d;
    } entry_t;
    logic [1:0] cnt_r;
    entry_t     e0_r, e1_r, in_e;
    logic       acc;
    assign in_e     = '{q: q, d: data};
    assign ready    = cnt_r != SKID_DEPTH;
    assign acc      = valid && ready;
    assign head_vld = cnt_r != 2'd0;
    assign head_q   = e0_r.q;
    assign head_d   = e0_r.d;
    // e0 is always the head; e1 only holds a word while the buffer is full
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_r <= '0;
            e0_r  <= '0;
            e1_r  <= '0;
        end else begin
            cnt_r <= cnt_r + {1'b0, acc} - {1'b0, pop};
            if (pop) e0_r <= (cnt_r == SKID_DEPTH) ? e1_r : in_e;
            else if (acc && cnt_r == 2'd0) e0_r <= in_e;
            if (acc && !pop && cnt_r == 2'd1) e1_r <= in_e;
        end
    end
endmodule

// File: rtl/mq_push_arb.sv
// mq_push_arb: round-robin push arbiter feeding the shared multi-queue FIFO.
// Heads aimed at a full queue are skipped rather than stalled on.
module mq_push_arb
    import mq_fifo_pkg::*;
#(
    parameter int P = 4,
    parameter int Q = 4,
    parameter int W = 32
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [P-1:0]                 in_valid,
    output logic [P-1:0]                 in_ready,
    input  logic [P-1:0][$clog2(Q)-1:0]  in_q,
    input  logic [P-1:0][W-1:0]          in_data,
    input  logic [Q-1:0]                 queue_full,
    output logic                         push,
    output logic [$clog2(Q)-1:0]         pushq,
    output logic [W-1:0]                 pushDat,
    output logic                         err_badq
);
    localparam int QW = $clog2(Q);
    localparam int PW = $clog2(P);
    logic [P-1:0]          head_vld, bad, elig, pop;
    logic [P-1:0][QW-1:0]  head_q;
    logic [P-1:0][W-1:0]   head_d;
    logic [2**QW-1:0]      full_x;
    logic [PW-1:0]         rr_r, win;
    // unused queue ids read as full so they can never be granted
    always_comb begin
        full_x = '1;
        full_x[Q-1:0] = queue_full;
    end
    for (genvar p = 0; p < P; p++) begin : g_prod
        mq_push_skid #(.QW(QW), .W(W)) u_skid (
            .clk      (clk),
            .rstn     (rstn),
            .valid    (in_valid[p]),
            .ready    (in_ready[p]),
            .q        (in_q[p]),
            .data     (in_data[p]),
            .pop      (pop[p]),
            .head_vld (head_vld[p]),
            .head_q   (head_q[p]),
            .head_d   (head_d[p])
        );
        assign bad[p]  = head_vld[p] && int'(head_q[p]) >= Q;
        assign elig[p] = head_vld[p] && !bad[p] && !full_x[head_q[p]];
        assign pop[p]  = bad[p] || (push && win == PW'(p));
    end
    always_comb begin
        push = 1'b0;
        win  = '0;
        for (int i = 0; i < P; i++) begin
            if (!push && elig[(int'(rr_r) + i) % P]) begin
                push = 1'b1;
                win  = PW'((int'(rr_r) + i) % P);
            end
        end
        pushq   = push ? head_q[win] : '0;
        pushDat = push ? head_d[win] : '0;
    end
    assign err_badq = |bad;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) rr_r <= '0;
        else if (push) rr_r <= (int'(win) == P - 1) ? '0 : win + 1'b1;
    end
endmodule

// File: tb/tb_mq_push_arb.sv
// tb_mq_push_arb: directed stimulus, queue-based reference model checked every cycle.
module tb_mq_push_arb;
    localparam int P = 4;
    localparam int Q = 4;
    localparam int W = 32;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;
    logic [P-1:0]         in_valid = '0;
    logic [P-1:0]         in_ready;
    logic [P-1:0][1:0]    in_q = '0;
    logic [P-1:0][W-1:0]  in_data = '0;
    logic [Q-1:0]         queue_full = '0;
    logic                 push, err_badq;
    logic [1:0]           pushq;
    logic [W-1:0]         pushDat;
    mq_push_arb #(.P(P), .Q(Q), .W(W)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .in_q(in_q), .in_data(in_data), .queue_full(queue_full),
        .push(push), .pushq(pushq), .pushDat(pushDat), .err_badq(err_badq)
    );
    logic [1:0]           v3 = '0;
    logic [1:0]           r3;
    logic [1:0][1:0]      q3 = '0;
    logic [1:0][W-1:0]    d3 = '0;
    logic [2:0]           full3 = '0;
    logic                 push3, bad3;
    logic [1:0]           pushq3;
    logic [W-1:0]         dat3;
    mq_push_arb #(.P(2), .Q(3), .W(W)) dut3 (
        .clk(clk), .rstn(rstn), .in_valid(v3), .in_ready(r3),
        .in_q(q3), .in_data(d3), .queue_full(full3),
        .push(push3), .pushq(pushq3), .pushDat(dat3), .err_badq(bad3)
    );
    int checks = 0;
    int errors = 0;
    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask
    typedef struct {
        logic [1:0]   q;
        logic [W-1:0] d;
    } ent_t;
    ent_t mq[P][$];
    int   rr = 0;
    function automatic bit busy();
        for (int i = 0; i < P; i++) if (mq[i].size() != 0) return 1'b1;
        return 1'b0;
    endfunction
    // model: per-producer word queues plus a round-robin pointer
    always @(negedge clk) begin
        int win, pp;
        logic [W-1:0] eq, ed;
        logic [P-1:0] a;
        if (!rstn) begin
            for (int i = 0; i < P; i++) mq[i].delete();
            rr = 0;
        end else begin
            win = -1;
            for (int i = 0; i < P; i++) begin
                pp = (rr + i) % P;
                if (win < 0 && mq[pp].size() > 0 && !queue_full[mq[pp][0].q]) win = pp;
            end
            eq = '0;
            ed = '0;
            if (win >= 0) begin
                eq = W'(mq[win][0].q);
                ed = mq[win][0].d;
            end
            chk("m_push", W'(push), W'(win >= 0));
            chk("m_pushq", W'(pushq), eq);
            chk("m_pushDat", pushDat, ed);
            chk("m_err_badq", W'(err_badq), '0);
            for (int i = 0; i < P; i++) begin
                chk("m_in_ready", W'(in_ready[i]), W'(mq[i].size() != 2));
                a[i] = in_valid[i] && mq[i].size() < 2;
            end
            if (win >= 0) begin
                void'(mq[win].pop_front());
                rr = (win + 1) % P;
            end
            for (int i = 0; i < P; i++) if (a[i]) mq[i].push_back('{in_q[i], in_data[i]});
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end
    initial begin
        logic [P-1:0] acc;
        int seq[P];
        repeat (2) @(posedge clk);
        #1;
        chk("rst_push", W'(push), '0);
        chk("rst_pushq", W'(pushq), '0);
        chk("rst_pushDat", pushDat, '0);
        chk("rst_err", W'(err_badq), '0);
        chk("rst_ready", W'(in_ready), W'(4'hF));
        rstn = 1'b1;
        tick();
        // single word from producer 0
        in_valid = 4'b0001;
        in_q[0] = 2'd2;
        in_data[0] = 32'hA5;
        tick();
        in_valid = '0;
        #1;
        chk("t1_push", W'(push), 1);
        chk("t1_pushq", W'(pushq), 2);
        chk("t1_pushDat", pushDat, 32'hA5);
        chk("t1_ready0", W'(in_ready[0]), 1);
        tick();
        #1;
        chk("t1_idle", W'(push), '0);
        tick();
        // all producers streaming; rr is 1 after the single grant above
        for (int p = 0; p < P; p++) begin
            seq[p] = 0;
            in_q[p] = 2'(p);
        end
        for (int c = 0; c < 12; c++) begin
            for (int p = 0; p < P; p++) in_data[p] = (p << 16) | seq[p];
            in_valid = '1;
            #1;
            if (c >= 1 && c <= 8) chk("t2_rot", W'(pushq), W'(c % 4));
            acc = in_valid & in_ready;
            tick();
            for (int p = 0; p < P; p++) if (acc[p]) seq[p]++;
        end
        in_valid = '0;
        for (int c = 0; c < 20 && busy(); c++) tick();
        chk("t2_drained", W'(busy()), '0);
        // skip over a head blocked by a full queue
        queue_full = 4'b0010;
        in_valid = 4'b0011;
        in_q[0] = 2'd1;
        in_data[0] = 32'h100;
        in_q[1] = 2'd3;
        in_data[1] = 32'h300;
        tick();
        in_valid = '0;
        #1;
        chk("t3_push", W'(push), 1);
        chk("t3_pushq", W'(pushq), 3);
        chk("t3_pushDat", pushDat, 32'h300);
        tick();
        #1;
        chk("t3_blocked", W'(push), '0);
        tick();
        queue_full = '0;
        #1;
        chk("t3_rel_push", W'(push), 1);
        chk("t3_rel_pushq", W'(pushq), 1);
        chk("t3_rel_pushDat", pushDat, 32'h100);
        tick();
        // fill producer 2 while every queue is full
        queue_full = '1;
        in_valid = 4'b0100;
        seq[2] = 0;
        for (int c = 0; c < 4; c++) begin
            in_q[2] = 2'(seq[2]);
            in_data[2] = 32'h201 + seq[2];
            #1;
            acc = in_valid & in_ready;
            tick();
            if (acc[2]) seq[2]++;
        end
        chk("t4_accepts", W'(seq[2]), 2);
        chk("t4_ready2", W'(in_ready[2]), '0);
        in_q[2] = 2'd2;
        in_data[2] = 32'h203;
        queue_full = '0;
        #1;
        chk("t4_w1", pushDat, 32'h201);
        tick();
        #1;
        chk("t4_w2", pushDat, 32'h202);
        tick();
        in_valid = '0;
        #1;
        chk("t4_w3", pushDat, 32'h203);
        tick();
        tick();
        // async reset with every skid full
        queue_full = '1;
        in_valid = '1;
        for (int c = 0; c < 2; c++) begin
            for (int p = 0; p < P; p++) in_data[p] = 32'h600 + p * 16 + c;
            tick();
        end
        in_valid = '0;
        chk("t6_full", W'(in_ready), '0);
        queue_full = '0;
        #1;
        chk("t6_pre_push", W'(push), 1);
        rstn = 1'b0;
        #1;
        chk("t6_rst_push", W'(push), '0);
        chk("t6_rst_pushDat", pushDat, '0);
        chk("t6_rst_ready", W'(in_ready), W'(4'hF));
        tick();
        rstn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("t6_stale", W'(push), '0);
        end
        // Q=3 instance: an out-of-range queue id is dropped
        v3 = 2'b10;
        q3[1] = 2'd3;
        d3[1] = 32'h11;
        tick();
        q3[1] = 2'd2;
        d3[1] = 32'h22;
        #1;
        chk("t5_err", W'(bad3), 1);
        chk("t5_nopush", W'(push3), '0);
        tick();
        v3 = '0;
        #1;
        chk("t5_err_once", W'(bad3), '0);
        chk("t5_push", W'(push3), 1);
        chk("t5_pushq", W'(pushq3), 2);
        chk("t5_pushDat", dat3, 32'h22);
        tick();
        #1;
        chk("t5_idle", W'(push3), '0);
        chk("t5_idle_err", W'(bad3), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
